// File: rtl/cskip_sub_pipe.sv
// Pipelined carry-skip subtractor computing d = a - b - bin as a + ~b + ~bin.
// Each pipeline stage resolves one BLOCK-bit ripple-plus-skip block.
module cskip_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  localparam int STAGES = WIDTH / BLOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  d,
  output logic              bout,
  output logic              ovf,
  output logic              zero,
  output logic [STAGES-1:0] skip
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // The whole pipe advances together when the output slot is empty or being
  // drained, so in_ready is that shared enable and bubbles hold like data.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Returns {skip, carry_out, sum} for one block of a + ~b + ci.
  function automatic logic [BLOCK+1:0] resolve(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] s;
    logic [BLOCK:0]   c;
    p    = x ^ ~y;
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (x[i] & ~y[i]) | (p[i] & c[i]);
    end
    return {&p, (&p) ? ci : c[BLOCK], s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = BLOCK * k;
    localparam int REM = WIDTH - LO - BLOCK;

    logic                   v_i;
    logic                   c_i;
    logic [WIDTH-LO-1:0]    a_i;
    logic [WIDTH-LO-1:0]    b_i;
    logic [BLOCK+1:0]       r;
    logic                   v_q;
    logic [LO+BLOCK-1:0]    s_q;
    logic [k:0]             sk_q;

    assign r = resolve(a_i[BLOCK-1:0], b_i[BLOCK-1:0], c_i);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (en) begin
        v_q <= v_i;
      end
    end

    if (k == 0) begin : g_src
      assign v_i = in_valid;
      assign c_i = ~bin;
      assign a_i = a;
      assign b_i = b;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q  <= '0;
          sk_q <= '0;
        end else if (en) begin
          s_q  <= r[BLOCK-1:0];
          sk_q <= r[BLOCK+1];
        end
      end
    end else begin : g_src
      assign v_i = g_stage[k-1].v_q;
      assign c_i = g_stage[k-1].g_fwd.c_q;
      assign a_i = g_stage[k-1].g_fwd.a_q;
      assign b_i = g_stage[k-1].g_fwd.b_q;

      // New block bits land on top of the already-resolved lower bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q  <= '0;
          sk_q <= '0;
        end else if (en) begin
          s_q  <= {r[BLOCK-1:0], g_stage[k-1].s_q};
          sk_q <= {r[BLOCK+1], g_stage[k-1].sk_q};
        end
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;
      logic           c_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (en) begin
          a_q <= a_i[WIDTH-LO-1:BLOCK];
          b_q <= b_i[WIDTH-LO-1:BLOCK];
          c_q <= r[BLOCK];
        end
      end
    end else begin : g_last
      logic bo_q;
      logic ov_q;
      logic p_msb;

      // Carry into the MSB is recovered as sum ^ propagate at that bit.
      assign p_msb = a_i[BLOCK-1] ^ ~b_i[BLOCK-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bo_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (en) begin
          bo_q <= ~r[BLOCK];
          ov_q <= r[BLOCK-1] ^ p_msb ^ r[BLOCK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign d         = g_stage[STAGES-1].s_q;
  assign skip      = g_stage[STAGES-1].sk_q;
  assign bout      = g_stage[STAGES-1].g_last.bo_q;
  assign ovf       = g_stage[STAGES-1].g_last.ov_q;
  assign zero      = (d == '0);

endmodule

// File: tb/tb_cskip_sub_pipe.sv
// Bench for cskip_sub_pipe: driver pushes expected results on input transfers,
// a negedge monitor pops and compares on output transfers.
module tb_cskip_sub_pipe;

  localparam int W  = 16;
  localparam int EW = W + 6;   // {skip[3:0], ovf, bout, d}

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;
  logic [3:0]   skip;

  logic [EW-1:0] exp_q[$];
  int            n_cmp;
  int            n_fail;
  bit            prev_stall;
  logic [W-1:0]  prev_d;
  logic [EW-1:0] e;

  // Hand-computed directed vectors: a, b, bin, d, bout, ovf, skip.
  logic [W-1:0] dir_a   [7] = '{16'h1234, 16'h5A5A, 16'h5A5A, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
  logic [W-1:0] dir_b   [7] = '{16'h0234, 16'h5A5A, 16'h5A5A, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
  logic         dir_bin [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] dir_d   [7] = '{16'h1000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
  logic         dir_bo  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         dir_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]   dir_sk  [7] = '{4'b0111, 4'b1111, 4'b1111, 4'b1110, 4'b0110, 4'b0111, 4'b1111};

  cskip_sub_pipe #(.WIDTH(W), .BLOCK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .skip      (skip)
  );

  // Clock / reset-time watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model built from plain integer arithmetic.
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic bi);
    logic [W:0] full;
    int         sr;
    logic       o;
    logic [3:0] sk;
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    sr   = int'($signed(x)) - int'($signed(y)) - int'(bi);
    o    = (sr > 32767) || (sr < -32768);
    for (int k = 0; k < 4; k++) sk[k] = (x[4*k +: 4] == y[4*k +: 4]);
    return {sk, o, full[W], full[W-1:0]};
  endfunction

  // Driver tasks
  task automatic cycle_op(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic bi, input bit ord, input logic [EW-1:0] ev,
                          output bit acc);
    in_valid  = v;
    a         = x;
    b         = y;
    bin       = bi;
    out_ready = ord;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) exp_q.push_back(ev);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                       input logic [EW-1:0] ev);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      cycle_op(1'b1, x, y, bi, 1'b1, ev, acc);
      n++;
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic lat_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input logic [EW-1:0] ev, input string name);
    int n;
    issue(x, y, bi, ev);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    @(posedge clk);
    #1;
    chk(name, n, 32'd4);
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_d", d, 32'd0);
      chk("rst_zero", zero, 32'd1);
      chk("rst_bout_ovf_skip", {bout, ovf, skip}, 32'd0);
      chk("rst_in_ready", in_ready, 32'd1);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (!out_valid || out_ready) ? 32'd1 : 32'd0);
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 32'd1);
        chk("stall_hold_d", d, prev_d);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("d", d, e[W-1:0]);
          chk("bout", bout, e[W]);
          chk("ovf", ovf, e[W+1]);
          chk("skip", skip, e[W+5:W+2]);
          chk("zero", zero, (e[W-1:0] == '0) ? 32'd1 : 32'd0);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = d;
    end
  end

  // Stimulus
  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bi;
    bit           acc;
    int           i;
    int           cyc;

    n_cmp      = 0;
    n_fail     = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    bin        = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors; first one also measures latency
    lat_op(dir_a[0], dir_b[0], dir_bin[0],
           {dir_sk[0], dir_ov[0], dir_bo[0], dir_d[0]}, "latency_basic");
    for (int k = 1; k < 7; k++)
      issue(dir_a[k], dir_b[k], dir_bin[k], {dir_sk[k], dir_ov[k], dir_bo[k], dir_d[k]});
    drain();

    // Back-to-back stream with a 3-cycle output stall
    i   = 0;
    cyc = 0;
    while (i < 8 && cyc < 100) begin
      x = W'(32'h1111 * i);
      y = W'(i);
      cycle_op(1'b1, x, y, 1'b0, !(cyc >= 5 && cyc <= 7), model(x, y, 1'b0), acc);
      if (acc) i++;
      cyc++;
    end
    chk("stream_issued", i, 32'd8);
    drain();

    // Reset mid-stream: three in flight, then discarded
    for (int k = 0; k < 3; k++) begin
      x = W'(32'h1000 * (k + 1));
      issue(x, 16'h0001, 1'b0, model(x, 16'h0001, 1'b0));
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    lat_op(16'h0042, 16'h0040, 1'b1, model(16'h0042, 16'h0040, 1'b1), "latency_after_reset");
    drain();

    // Random operands with random in_valid / out_ready
    i   = 0;
    cyc = 0;
    while (i < 10000 && cyc < 40000) begin
      x  = W'($urandom_range(0, 65535));
      y  = W'($urandom_range(0, 65535));
      bi = 1'($urandom_range(0, 1));
      cycle_op($urandom_range(0, 3) != 0, x, y, bi, $urandom_range(0, 3) != 0,
               model(x, y, bi), acc);
      if (acc) i++;
      cyc++;
    end
    chk("random_issued", i, 32'd10000);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cskip_sub_pipe.md
# cskip_sub_pipe

Pipelined 16-bit carry-skip subtractor computing d = a − b − bin, with a valid/ready handshake on both sides. It is the inverse arithmetic companion to the 4-bit carry-skip adder. It reuses the same 4-bit ripple-plus-skip block structure, with one skip block registered per pipeline stage, so the borrow chain never spans more than 4 bits per cycle. It sits between operand-producing logic and a result consumer, such as an ALU writeback or a compare unit, and sustains one subtraction per clock when not stalled.

## Interface
- WIDTH, 16, operand width; must be a multiple of BLOCK.
- BLOCK, 4, skip-block width; one block is resolved per pipeline stage.
- STAGES, WIDTH/BLOCK (4), pipeline depth; derived, not overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b/bin are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- d  output  WIDTH  difference, a − b − bin mod 2^WIDTH.
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed (two's-complement) overflow.
- zero  output  1  d == 0.
- skip  output  STAGES  per-block skip flag: bit k = 1 when block k's propagate bits were all 1, so its carry-out was taken from its carry-in.

## Operation
- **Arithmetic**
  - Subtraction is computed as a + ~b + cin with cin = ~bin.
  - Block k covers bits [BLOCK·k+BLOCK−1 : BLOCK·k].
  - Per-bit propagate: p = a ^ ~b.
  - Block skip: bp_k = &p over the block.
  - Block carry-out = bp_k ? block carry-in : ripple carry-out.
- **Outputs**
  - bout = ~(carry out of block STAGES−1).
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - zero is derived from the final registered d, not a separate compare.
- **Pipeline structure**
  - Stage k (k = 0..STAGES−1) resolves block k and registers: its sum bits, its carry-out, its skip flag, and the unresolved upper operand bits. Operand bits of later blocks are delayed alongside.
  - Lower result bits are carried forward through later stages.
  - Each stage holds a valid bit. The final stage's registers drive d, bout, ovf, zero, skip and out_valid.
- **Handshake**
  - Global advance enable: en = ~out_valid | out_ready.
  - in_ready = en (combinational from out_valid and out_ready).
  - When en = 1, every stage loads from its predecessor, and stage 0 loads in_valid and the operands.
  - When en = 0, all stage registers, including bubbles, hold.
  - Transfer in: in_valid & in_ready at a rising edge.
  - Transfer out: out_valid & out_ready at a rising edge.
  - Bubbles (in_valid = 0 while en = 1) propagate as valid = 0 and are never presented.
  - Result outputs hold stable while out_valid = 1 and out_ready = 0.
- **Reset**
  - rst asserted at any time, including mid-stream, immediately clears all stage valid bits and all data registers to 0.
  - In-flight operations are discarded and are not replayed.
  - Outputs during and after reset until the first result: out_valid = 0, d = 0, bout = 0, ovf = 0, skip = 0, zero = 1 (derived from d = 0).
  - in_ready = 1 during reset.

## Timing
- **Latency:** exactly STAGES (4) rising edges from the input transfer to out_valid = 1, when no stall occurs.
- **Throughput:** 1 result per cycle with out_ready held at 1.
- **Stalls:** each cycle with en = 0 adds one cycle of latency to every in-flight operation. Order is always preserved.
- **Simultaneous input and output transfer:** when both occur in the same cycle, both complete, and pipeline occupancy is unchanged.
- **Critical path:** one BLOCK-bit ripple plus a skip mux per stage, plus the en fan-out.

## Test plan
- **Basic subtraction:** a = 0x1234, b = 0x0234, bin = 0 → after 4 cycles d = 0x1000, bout = 0, ovf = 0, zero = 0.
- **Full skip chain:** a = b = 0x5A5A.
  - bin = 1 → d = 0xFFFF, bout = 1, skip = 4'b1111.
  - bin = 0 → d = 0x0000, zero = 1, bout = 0, skip = 4'b1111.
- **Underflow and overflow:**
  - 0x0000 − 0x0001 → d = 0xFFFF, bout = 1, ovf = 0.
  - 0x8000 − 0x0001 → d = 0x7FFF, bout = 0, ovf = 1.
- **Back-to-back with stall:** stream 8 operations (a = i·0x1111, b = i, bin = 0) with out_ready low for 3 cycles in the middle. Required: all 8 results appear in order, with in_ready = 0 exactly during the stall while out_valid = 1, and d held stable.
- **Reset mid-stream:** issue 3 operations, then assert rst for 1 cycle on the cycle after the 3rd transfer. Required: out_valid = 0 immediately; none of the 3 results ever appears; the next operation after reset has 4-cycle latency.
- **Random:** 10k random a/b/bin with random in_valid and out_ready, checked against a − b − bin reference for d, bout and ovf, and against a scoreboard for ordering.
